// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and constants for the UART transmit scheduler
//
// Purpose : FSM state encoding and constants used by uart_tx_sched.
// Contents: state_t  - scheduler states S_IDLE..S_WAIT_DONE
//           TAG_HI   - upper nibble of the optional tag byte
//           TMO_W    - width of the strobe/timeout counters
package uart_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  localparam logic [3:0] TAG_HI = 4'hA;
  localparam int         TMO_W  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
//
// Purpose : selects the first asserted request at or after the pointer,
//           wrapping from NREQ-1 back to 0.
// Ports   : req        in  NREQ  request vector
//           ptr        in  IDW   round-robin start index
//           gnt_valid  out 1     at least one request asserted
//           gnt_id     out IDW   index of the selected request
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id
);

  localparam logic [IDW:0] NREQ_X = (IDW+1)'(NREQ);

  logic [IDW:0] idx;

  // Scan from the furthest offset down to offset 0 so the candidate
  // closest to the pointer is the one left standing.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= NREQ_X) begin
        idx = idx - NREQ_X;
      end
      if (req[idx[IDW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler in front of a single UART byte transmitter
//
// Purpose : accepts one byte at a time from NREQ sources, presents it on tx_datain,
//           strobes tx_wrsig and sequences each frame on the transmitter's idle flag
//           (tx_idle = 1 while a frame is on the line).
// Ports   : clk, reset (sync, active-high)
//           req_valid/req_data/req_ready - per-source byte handshake, ready is a 1-cycle pulse
//           tx_datain/tx_wrsig/tx_idle   - transmitter interface
//           grant_id, busy, err_tmo      - status; err_tmo is sticky until reset
// Config  : UART_SCHED_TAG_EN - when defined, every grant sends a tag byte
//           {TAG_HI, 1'b0, id[2:0]} ahead of the data byte.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int WR_HOLD = 3,
  parameter int TMO     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_datain,
  output logic              tx_wrsig,
  input  logic              tx_idle,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              err_tmo
);

  localparam logic [TMO_W-1:0] HOLD_LAST = TMO_W'(WR_HOLD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO - 1);
  localparam logic [IDW-1:0]   ID_LAST   = IDW'(NREQ - 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [TMO_W-1:0] hold_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic             arb_valid;
  logic [IDW-1:0]   arb_id;
  logic [7:0]       arb_data;

`ifdef UART_SCHED_TAG_EN
  logic [7:0]       data_q;
  logic             data_phase;  // 0: tag frame on the line, 1: data frame
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  assign arb_data = req_data[{arb_id, 3'b000} +: 8];
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      req_ready <= '0;
      tx_datain <= 8'h00;
      tx_wrsig  <= 1'b0;
      grant_id  <= '0;
      err_tmo   <= 1'b0;
`ifdef UART_SCHED_TAG_EN
      data_q     <= 8'h00;
      data_phase <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          // A frame may still be running (e.g. across a reset): never
          // strobe until the line is seen free.
          if (arb_valid && !tx_idle) begin
            grant_id          <= arb_id;
            req_ready[arb_id] <= 1'b1;
`ifdef UART_SCHED_TAG_EN
            tx_datain  <= {TAG_HI, 1'b0, 3'(arb_id)};
            data_q     <= arb_data;
            data_phase <= 1'b0;
`else
            tx_datain  <= arb_data;
`endif
            state <= S_LOAD;
          end
        end

        // wrsig is low during this cycle, so the transmitter sees a clean
        // rising edge when it goes high on the way into S_STROBE.
        S_LOAD: begin
          tx_wrsig <= 1'b1;
          hold_cnt <= '0;
          tmo_cnt  <= '0;
          state    <= S_STROBE;
        end

        S_STROBE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            tx_wrsig <= 1'b0;
            state    <= S_WAIT_BUSY;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        // tmo_cnt keeps counting from the first strobe cycle.
        S_WAIT_BUSY: begin
          if (tx_idle) begin
            state <= S_WAIT_DONE;
          end else if (tmo_cnt >= TMO_LAST) begin
            err_tmo <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (!tx_idle) begin
`ifdef UART_SCHED_TAG_EN
            if (!data_phase) begin
              data_phase <= 1'b1;
              tx_datain  <= data_q;
              state      <= S_LOAD;
            end else begin
              rr_ptr <= (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
              state  <= S_IDLE;
            end
`else
            rr_ptr <= (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
            state  <= S_IDLE;
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int WR_HOLD = 3;
  localparam int TMO     = 255;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_datain;
  logic              tx_wrsig;
  logic              tx_idle;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              err_tmo;

  uart_tx_sched #(
    .NREQ(NREQ), .IDW(IDW), .WR_HOLD(WR_HOLD), .TMO(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_datain (tx_datain),
    .tx_wrsig  (tx_wrsig),
    .tx_idle   (tx_idle),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_tmo   (err_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] data;
    int         id;
    int         rcyc;
    bit         first;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mptr = 0;
  bit   hog [NREQ];
  exp_t exp_q [$];
  int   order_q [$];
  logic [7:0] sent_q [$];

  bit         wr_prev = 0;
  int         hi_len = 0;
  int         rise_cnt = 0;
  int         fall_cnt = 0;
  int         force_cnt = 0;
  bit         dead = 0;
  bit         in_frame = 0;
  bit         unstable = 0;
  logic [7:0] frame_data = 8'h00;
  int         wr_edges = 0;
  int         frames_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock step; all bench-side models advance at the falling edge.
  task automatic tick();
    int   e;
    exp_t x;
    @(negedge clk);
    cyc++;

    // Transmitter model: idle rises 3 cycles after a wrsig rising edge
    // and falls 169 cycles after that.
    if (force_cnt > 0) begin
      force_cnt--;
      tx_idle = (force_cnt != 0);
    end else if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        tx_idle  = 1'b1;
        fall_cnt = 169;
      end
    end else if (fall_cnt > 0) begin
      fall_cnt--;
      if (fall_cnt == 0) begin
        tx_idle = 1'b0;
        if (in_frame) begin
          chk("datain_stable", 32'(unstable), 32'd0);
          in_frame = 0;
          frames_done++;
        end
      end
    end

    if (in_frame && tx_datain !== frame_data) unstable = 1;

    if (tx_wrsig && !wr_prev) begin
      wr_edges++;
      frame_data = tx_datain;
      in_frame   = 1;
      unstable   = 0;
      sent_q.push_back(tx_datain);
      if (!dead) rise_cnt = 3;
      if (exp_q.size() == 0) begin
        chk("frame_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        x = exp_q.pop_front();
        chk("frame_data", 32'(tx_datain), 32'(x.data));
        chk("frame_gnt", 32'(grant_id), 32'(x.id));
        if (x.first) chk("latency", 32'(cyc - x.rcyc), 32'd1);
      end
    end
    if (tx_wrsig) begin
      hi_len++;
    end else if (wr_prev) begin
      chk("wr_hold", 32'(hi_len), 32'(WR_HOLD));
      hi_len = 0;
    end
    wr_prev = tx_wrsig;

    // Ready pulse: the accept happened at the previous rising edge against
    // the request vector still being driven now.
    if (req_ready != '0) begin
      e = -1;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[(mptr + k) % NREQ]) e = (mptr + k) % NREQ;
      end
      if (e < 0) begin
        chk("ready_spurious", 32'(req_ready), 32'd0);
      end else begin
        chk("ready_onehot", 32'(req_ready), 32'(1 << e));
        chk("grant_id", 32'(grant_id), 32'(e));
        chk("busy_on_grant", 32'(busy), 32'd1);
        order_q.push_back(e);
`ifdef UART_SCHED_TAG_EN
        exp_q.push_back('{8'hA0 | 8'(e), e, cyc, 1'b1});
        exp_q.push_back('{req_data[8*e +: 8], e, cyc, 1'b0});
`else
        exp_q.push_back('{req_data[8*e +: 8], e, cyc, 1'b1});
`endif
        if (!dead) mptr = (e + 1) % NREQ;
        if (hog[e]) req_data[8*e +: 8] = 8'($urandom);
        else        req_valid[e] = 1'b0;
      end
    end
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while (!(busy == 1'b0 && req_valid == '0 && exp_q.size() == 0 &&
             tx_idle == 1'b0 && !in_frame) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk({tag, "_quiet_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mptr = 0;
    exp_q.delete();
    order_q.delete();
  endtask

  task automatic post(input int id, input logic [7:0] d, input bit h);
    req_valid[id]        = 1'b1;
    req_data[8*id +: 8]  = d;
    hog[id]              = h;
  endtask

  initial begin
    int n;
    int snap;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_idle   = 1'b0;
    for (int i = 0; i < NREQ; i++) hog[i] = 0;
    tick();
    tick();

    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_datain", 32'(tx_datain), 32'd0);
    chk("rst_wrsig", 32'(tx_wrsig), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_tmo), 32'd0);
    reset = 1'b0;
    tick();

    // Single requester
    post(1, 8'h5A, 0);
    wait_quiet("single");
    chk("single_count", 32'(order_q.size()), 32'd1);
    chk("single_byte", 32'(sent_q[sent_q.size()-1]), 32'h5A);

    // Contention from pointer 0
    do_reset();
    for (int i = 0; i < NREQ; i++) post(i, 8'(8'h10 + i), 0);
    wait_quiet("contend");
    chk("contend_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) chk("contend_order", 32'(order_q[i]), 32'(i));

    // Hog on 0, single byte on 2
    do_reset();
    post(0, 8'h01, 1);
    post(2, 8'h22, 0);
    n = 0;
    while (order_q.size() < 4 && n < 2000) begin tick(); n++; end
    req_valid[0] = 1'b0;
    hog[0] = 0;
    wait_quiet("hog");
    if (order_q.size() >= 4) begin
      chk("hog_o0", 32'(order_q[0]), 32'd0);
      chk("hog_o1", 32'(order_q[1]), 32'd2);
      chk("hog_o2", 32'(order_q[2]), 32'd0);
      chk("hog_o3", 32'(order_q[3]), 32'd0);
    end else begin
      chk("hog_count", 32'(order_q.size()), 32'd4);
    end

    // Randomised rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) post(i, 8'($urandom), ($urandom_range(0, 3) == 0));
      end
      if (req_valid == '0) post(int'($urandom_range(0, NREQ-1)), 8'($urandom), 0);
      snap = frames_done + 5;
      n = 0;
      while (frames_done < snap && req_valid != '0 && n < 2000) begin tick(); n++; end
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) hog[i] = 0;
      wait_quiet("random");
    end

    // Strobe timeout: transmitter never goes busy
    dead = 1;
    post(1, 8'h77, 0);
    n = 0;
    while (!err_tmo && n < 600) begin tick(); n++; end
    chk("tmo_err", 32'(err_tmo), 32'd1);
    chk("tmo_window", 32'(n > TMO - 10 && n < TMO + 20), 32'd1);
    tick();
    chk("tmo_idle", 32'(busy), 32'd0);
    dead = 0;
    in_frame = 0;
    post(3, 8'h33, 0);
    wait_quiet("after_tmo");
    chk("tmo_sticky", 32'(err_tmo), 32'd1);
    chk("tmo_next_byte", 32'(sent_q[sent_q.size()-1]), 32'h33);

    // Reset while a frame is on the line
    post(0, 8'h44, 0);
    n = 0;
    while (!tx_idle && n < 100) begin tick(); n++; end
    post(2, 8'h22, 0);
    reset     = 1'b1;
    rise_cnt  = 0;
    fall_cnt  = 0;
    in_frame  = 0;
    force_cnt = 100;
    tx_idle   = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    mptr  = 0;
    chk("rmf_err_clr", 32'(err_tmo), 32'd0);
    chk("rmf_busy", 32'(busy), 32'd0);
    snap = wr_edges;
    for (int i = 0; i < 98; i++) tick();
    chk("rmf_no_strobe", 32'(wr_edges - snap), 32'd0);
    wait_quiet("rmf");
    chk("rmf_served", 32'(sent_q[sent_q.size()-1]), 32'h22);

    // Requester 3 with byte C3 (tag frame first when tagging is built in)
    post(3, 8'hC3, 0);
    wait_quiet("tag");
    chk("tag_data", 32'(sent_q[sent_q.size()-1]), 32'hC3);
`ifdef UART_SCHED_TAG_EN
    chk("tag_byte", 32'(sent_q[sent_q.size()-2]), 32'hA3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
